// File: rtl/countdown_timer.sv
// Cook-time countdown: loads a clamped mm:ss setting, decrements once per enabled 1 Hz tick, flags zero.
// Counters update on the sampling edge; bargraph trails them by one cycle. No backpressure: strobes are never stalled.
module countdown_timer #(
    parameter int MAX_MINUTES = 99,
    parameter int MIN_WIDTH   = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick_1hz,
    input  logic                 load_timer,
    input  logic                 main_timer_enable,
    input  logic [MIN_WIDTH-1:0] set_minutes,
    input  logic [5:0]           set_seconds,
    output logic [MIN_WIDTH-1:0] minutes,
    output logic [5:0]           seconds,
    output logic                 timer_done,
    output logic                 done_pulse,
    output logic [7:0]           bargraph
);

    localparam logic [MIN_WIDTH-1:0] MAX_MIN = MIN_WIDTH'(MAX_MINUTES);
    localparam logic [5:0]           MAX_SEC = 6'd59;

    logic [MIN_WIDTH-1:0] minutes_q, minutes_d;
    logic [5:0]           seconds_q, seconds_d;
    logic [12:0]          remaining_q, remaining_d;
    logic [12:0]          loaded_q, loaded_d;
    logic                 done_q, done_d;
    logic                 pulse_q, pulse_d;
    logic [7:0]           bar_q, bar_d;

    logic [MIN_WIDTH-1:0] clamp_min;
    logic [5:0]           clamp_sec;
    logic [12:0]          min13;
    logic [12:0]          load_total;
    logic                 count_en;

    // m*60 = m*64 - m*4; 99*64 still fits in 13 bits
    always_comb begin
        clamp_min  = (set_minutes > MAX_MIN) ? MAX_MIN : set_minutes;
        clamp_sec  = (set_seconds > MAX_SEC) ? MAX_SEC : set_seconds;
        min13      = 13'(clamp_min);
        load_total = (min13 << 6) - (min13 << 2) + 13'(clamp_sec);
        count_en   = tick_1hz & main_timer_enable & (remaining_q != 13'd0);
    end

    always_comb begin
        minutes_d   = minutes_q;
        seconds_d   = seconds_q;
        remaining_d = remaining_q;
        loaded_d    = loaded_q;
        pulse_d     = 1'b0;
        if (load_timer) begin
            minutes_d   = clamp_min;
            seconds_d   = clamp_sec;
            remaining_d = load_total;
            loaded_d    = load_total;
        end else if (count_en) begin
            if (seconds_q != 6'd0) begin
                seconds_d = seconds_q - 6'd1;
            end else begin
                minutes_d = minutes_q - MIN_WIDTH'(1);
                seconds_d = MAX_SEC;
            end
            remaining_d = remaining_q - 13'd1;
            pulse_d     = (remaining_q == 13'd1);
        end
        done_d = (remaining_d == 13'd0);
    end

    logic [15:0] rem_x8;
    logic [15:0] ld16;
    logic [15:0] ld_k;

    // Thermometer from the registered totals; 5999*8 fits the 16-bit compare
    always_comb begin
        bar_d  = 8'h00;
        ld_k   = 16'd0;
        rem_x8 = {remaining_q, 3'b000};
        ld16   = {3'b000, loaded_q};
        for (int k = 0; k < 8; k++) begin
            ld_k = (k[0] ? ld16 : 16'd0)
                 + (k[1] ? (ld16 << 1) : 16'd0)
                 + (k[2] ? (ld16 << 2) : 16'd0);
            bar_d[k] = (rem_x8 > ld_k);
        end
        if (remaining_q == 13'd0 || loaded_q == 13'd0) begin
            bar_d = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            minutes_q   <= '0;
            seconds_q   <= 6'd0;
            remaining_q <= 13'd0;
            loaded_q    <= 13'd0;
            done_q      <= 1'b1;
            pulse_q     <= 1'b0;
            bar_q       <= 8'h00;
        end else begin
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            remaining_q <= remaining_d;
            loaded_q    <= loaded_d;
            done_q      <= done_d;
            pulse_q     <= pulse_d;
            bar_q       <= bar_d;
        end
    end

    assign minutes    = minutes_q;
    assign seconds    = seconds_q;
    assign timer_done = done_q;
    assign done_pulse = pulse_q;
    assign bargraph   = bar_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed stimulus with a queued scoreboard; a negedge monitor pops and compares every cycle.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       load_timer = 1'b0;
    logic       main_timer_enable = 1'b0;
    logic [6:0] set_minutes = 7'd0;
    logic [5:0] set_seconds = 6'd0;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       timer_done;
    logic       done_pulse;
    logic [7:0] bargraph;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         mins;
        int         secs;
        logic       done;
        logic       pulse;
        logic [7:0] bar;
    } exp_t;

    exp_t sb[$];

    int         m_rem    = 0;
    int         m_loaded = 0;
    logic       m_pulse  = 1'b0;
    logic [7:0] m_bar    = 8'h00;

    always #5 clk = ~clk;

    countdown_timer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .tick_1hz          (tick_1hz),
        .load_timer        (load_timer),
        .main_timer_enable (main_timer_enable),
        .set_minutes       (set_minutes),
        .set_seconds       (set_seconds),
        .minutes           (minutes),
        .seconds           (seconds),
        .timer_done        (timer_done),
        .done_pulse        (done_pulse),
        .bargraph          (bargraph)
    );

    function automatic logic [7:0] bar_of(input int r, input int l);
        logic [7:0] b;
        b = 8'h00;
        if (r != 0 && l != 0) begin
            for (int k = 0; k < 8; k++) b[k] = (r * 8 > l * k);
        end
        return b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rem    = 0;
        m_loaded = 0;
        m_pulse  = 1'b0;
        m_bar    = 8'h00;
    endtask

    task automatic push_exp();
        exp_t e;
        e.mins  = m_rem / 60;
        e.secs  = m_rem % 60;
        e.done  = (m_rem == 0);
        e.pulse = m_pulse;
        e.bar   = m_bar;
        sb.push_back(e);
    endtask

    task automatic model_clock(input logic ld, input logic tk, input logic en,
                               input int sm, input int ss);
        logic [7:0] bar_n;
        int cm, cs;
        if (!reset_n) begin
            model_reset();
            return;
        end
        bar_n   = bar_of(m_rem, m_loaded);
        m_pulse = 1'b0;
        if (ld) begin
            cm       = (sm > 99) ? 99 : sm;
            cs       = (ss > 59) ? 59 : ss;
            m_rem    = cm * 60 + cs;
            m_loaded = m_rem;
        end else if (tk && en && m_rem != 0) begin
            m_rem   = m_rem - 1;
            m_pulse = (m_rem == 0);
        end
        m_bar = bar_n;
    endtask

    task automatic step(input logic ld, input logic tk, input logic en,
                        input int sm = 0, input int ss = 0);
        load_timer        = ld;
        tick_1hz          = tk;
        main_timer_enable = en;
        set_minutes       = 7'(sm);
        set_seconds       = 6'(ss);
        @(posedge clk);
        model_clock(ld, tk, en, sm, ss);
        #1;
        push_exp();
    endtask

    // Asserts reset between edges; the following negedge must already show reset values.
    task automatic reset_mid_cycle();
        load_timer = 1'b0;
        tick_1hz   = 1'b0;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        model_reset();
        push_exp();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("minutes",    int'(minutes),    e.mins);
                check("seconds",    int'(seconds),    e.secs);
                check("timer_done", int'(timer_done), int'(e.done));
                check("done_pulse", int'(done_pulse), int'(e.pulse));
                check("bargraph",   int'(bargraph),   int'(e.bar));
            end
        end
    end

    initial begin
        repeat (3) step(0, 0, 0);
        reset_n = 1'b1;
        repeat (3) step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 1);

        // 1:05 down through 0:00, then one extra tick
        step(1, 0, 1, 1, 5);
        repeat (66) step(0, 1, 1);
        repeat (2) step(0, 0, 1);

        // 0:08 with a tick every fourth cycle for the bargraph walk
        step(1, 0, 1, 0, 8);
        repeat (9) begin
            step(0, 1, 1);
            repeat (3) step(0, 0, 1);
        end

        // 2:00 with enable dropped mid-run
        step(1, 0, 1, 2, 0);
        repeat (3) step(0, 1, 1);
        repeat (5) step(0, 1, 0);
        step(0, 1, 1);
        repeat (2) step(0, 0, 1);

        // Clamping, load priority over tick, load while disabled, zero load
        step(1, 1, 1, 120, 63);
        repeat (2) step(0, 0, 1);
        step(1, 0, 0, 0, 60);
        step(0, 1, 0);
        step(1, 0, 1, 0, 0);
        step(0, 1, 1);
        step(0, 0, 1);

        // Reset asserted between edges at 0:30
        step(1, 0, 1, 0, 40);
        repeat (10) step(0, 1, 1);
        step(0, 0, 1);
        reset_mid_cycle();
        repeat (2) step(0, 1, 1);
        reset_n = 1'b1;
        repeat (2) step(0, 1, 1);

        // Shortest nonzero countdown
        step(1, 0, 1, 0, 1);
        step(0, 0, 1);
        step(0, 1, 1);
        repeat (2) step(0, 0, 1);

        load_timer = 1'b0;
        tick_1hz   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
